// File: rtl/bullcow_game_param.sv
// Two-player Bulls and Cows controller: secret setup, alternating guesses,
// registered scoring, win counters and an optional round limit ending in a draw.
//
// state      | meaning
// J1_SETUP   | waiting for player 1 secret
// J2_SETUP   | waiting for player 2 secret
// J1_GUESS   | player 1 guesses against secret2
// J2_GUESS   | player 2 guesses against secret1
// DRAW       | round limit reached, enter starts a new game
// END_GAME   | a player scored all bulls, enter starts a new game
module bullcow_game_param #(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int BASE       = 10,
    parameter int PTS_W      = 8,
    parameter int MAX_ROUNDS = 0,
    localparam int CNT_W     = $clog2(DIGITS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [DIGITS*DIGIT_W-1:0] SW,
    output logic [CNT_W-1:0]          bull_count,
    output logic [CNT_W-1:0]          cow_count,
    output logic [2:0]                game_state,
    output logic [PTS_W-1:0]          J1_points,
    output logic [PTS_W-1:0]          J2_points,
    output logic                      invalid,
    output logic [7:0]                round
);

    typedef enum logic [2:0] {
        S_J1_SETUP = 3'b000,
        S_J2_SETUP = 3'b001,
        S_J1_GUESS = 3'b010,
        S_J2_GUESS = 3'b011,
        S_DRAW     = 3'b110,
        S_END_GAME = 3'b111
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [DIGITS*DIGIT_W-1:0]   r_secret1;
    logic [DIGITS*DIGIT_W-1:0]   r_secret2;
    logic [CNT_W-1:0]            r_bulls;
    logic [CNT_W-1:0]            r_cows;
    logic [PTS_W-1:0]            r_j1_pts;
    logic [PTS_W-1:0]            r_j2_pts;
    logic                        r_invalid;
    logic [7:0]                  r_round;

    logic                        w_valid;
    logic [DIGITS*DIGIT_W-1:0]   w_target;
    logic [CNT_W-1:0]            w_bulls;
    logic [CNT_W-1:0]            w_cows;
    logic                        w_hit;
    logic                        w_win;
    logic [7:0]                  w_round_inc;
    logic                        w_draw;
    logic                        w_entry_state;
    logic                        w_accept;
    logic                        w_restart;

    // Every digit in range and no digit repeated anywhere in the entry.
    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, SW[i*DIGIT_W +: DIGIT_W]} >= (DIGIT_W+1)'(BASE))
                w_valid = 1'b0;
            for (int j = i + 1; j < DIGITS; j++) begin
                if (SW[i*DIGIT_W +: DIGIT_W] == SW[j*DIGIT_W +: DIGIT_W])
                    w_valid = 1'b0;
            end
        end
    end

    assign w_target = (r_state == S_J1_GUESS) ? r_secret2 : r_secret1;

    always_comb begin
        w_bulls = '0;
        w_cows  = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (SW[k*DIGIT_W +: DIGIT_W] == w_target[k*DIGIT_W +: DIGIT_W]) begin
                w_bulls = w_bulls + CNT_W'(1);
            end else begin
                w_hit = 1'b0;
                for (int j = 0; j < DIGITS; j++) begin
                    if (j != k && SW[k*DIGIT_W +: DIGIT_W] == w_target[j*DIGIT_W +: DIGIT_W])
                        w_hit = 1'b1;
                end
                if (w_hit)
                    w_cows = w_cows + CNT_W'(1);
            end
        end
    end

    assign w_win         = (w_bulls == CNT_W'(DIGITS));
    assign w_round_inc   = (r_round == 8'hFF) ? r_round : r_round + 8'd1;
    assign w_draw        = (MAX_ROUNDS != 0) && (w_round_inc == 8'(MAX_ROUNDS));
    assign w_entry_state = (r_state == S_J1_SETUP) || (r_state == S_J2_SETUP) ||
                           (r_state == S_J1_GUESS) || (r_state == S_J2_GUESS);
    assign w_accept      = enter && w_entry_state && w_valid;
    assign w_restart     = enter && ((r_state == S_DRAW) || (r_state == S_END_GAME));

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_J1_SETUP;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_J1_SETUP: if (w_accept) w_next_state = S_J2_SETUP;
            S_J2_SETUP: if (w_accept) w_next_state = S_J1_GUESS;
            S_J1_GUESS: if (w_accept) w_next_state = w_win ? S_END_GAME : S_J2_GUESS;
            S_J2_GUESS: begin
                if (w_accept) begin
                    if (w_win)
                        w_next_state = S_END_GAME;
                    else if (w_draw)
                        w_next_state = S_DRAW;
                    else
                        w_next_state = S_J1_GUESS;
                end
            end
            S_DRAW, S_END_GAME: if (enter) w_next_state = S_J1_SETUP;
            default: w_next_state = S_J1_SETUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_secret1 <= '0;
            r_secret2 <= '0;
            r_bulls   <= '0;
            r_cows    <= '0;
            r_j1_pts  <= '0;
            r_j2_pts  <= '0;
            r_invalid <= 1'b0;
            r_round   <= '0;
        end else begin
            r_invalid <= enter && w_entry_state && !w_valid;
            if (w_accept) begin
                case (r_state)
                    S_J1_SETUP: r_secret1 <= SW;
                    S_J2_SETUP: r_secret2 <= SW;
                    S_J1_GUESS, S_J2_GUESS: begin
                        r_bulls <= w_bulls;
                        r_cows  <= w_cows;
                        if (w_win) begin
                            if (r_state == S_J1_GUESS && r_j1_pts != {PTS_W{1'b1}})
                                r_j1_pts <= r_j1_pts + PTS_W'(1);
                            if (r_state == S_J2_GUESS && r_j2_pts != {PTS_W{1'b1}})
                                r_j2_pts <= r_j2_pts + PTS_W'(1);
                        end else if (r_state == S_J2_GUESS) begin
                            r_round <= w_round_inc;
                        end
                    end
                    default: ;
                endcase
            end
            // Starting a new game wipes the board but keeps the score.
            if (w_restart) begin
                r_secret1 <= '0;
                r_secret2 <= '0;
                r_bulls   <= '0;
                r_cows    <= '0;
                r_round   <= '0;
            end
        end
    end

    assign bull_count = r_bulls;
    assign cow_count  = r_cows;
    assign game_state = r_state;
    assign J1_points  = r_j1_pts;
    assign J2_points  = r_j2_pts;
    assign invalid    = r_invalid;
    assign round      = r_round;

endmodule

// File: tb/tb_bullcow_game_param.sv
// Bench for bullcow_game_param: a default instance and a MAX_ROUNDS=2/PTS_W=2
// instance share one stimulus stream and are checked against a digit-set model.
module tb_bullcow_game_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] SW    = '0;

    logic [2:0] b0, c0, gs0, b1, c1, gs1;
    logic [7:0] p1_0, p2_0, rnd0, rnd1;
    logic [1:0] p1_1, p2_1;
    logic       inv0, inv1;

    int n_tests = 0;
    int n_fail  = 0;

    bullcow_game_param dut0 (
        .clock(clock), .reset(reset), .enter(enter), .SW(SW),
        .bull_count(b0), .cow_count(c0), .game_state(gs0),
        .J1_points(p1_0), .J2_points(p2_0), .invalid(inv0), .round(rnd0)
    );

    bullcow_game_param #(.MAX_ROUNDS(2), .PTS_W(2)) dut1 (
        .clock(clock), .reset(reset), .enter(enter), .SW(SW),
        .bull_count(b1), .cow_count(c1), .game_state(gs1),
        .J1_points(p1_1), .J2_points(p2_1), .invalid(inv1), .round(rnd1)
    );

    always #5 clock = ~clock;

    // Reference model, one slot per instance.
    int          m_st[2], m_b[2], m_c[2], m_p1[2], m_p2[2], m_rnd[2], m_inv[2];
    logic [15:0] m_s1[2], m_s2[2];
    int          m_maxr[2] = '{0, 2};
    int          m_pmax[2] = '{255, 3};

    function automatic bit is_valid(logic [15:0] v);
        bit [15:0] seen = '0;
        for (int i = 0; i < 4; i++) begin
            int d = int'(v[i*4 +: 4]);
            if (d >= 10 || seen[d]) return 1'b0;
            seen[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic int count_bulls(logic [15:0] g, logic [15:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) if (g[i*4 +: 4] == s[i*4 +: 4]) n++;
        return n;
    endfunction

    // Both sides have distinct digits, so cows = shared digits minus bulls.
    function automatic int count_common(logic [15:0] g, logic [15:0] s);
        bit [15:0] mg = '0, ms = '0;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            mg[g[i*4 +: 4]] = 1'b1;
            ms[s[i*4 +: 4]] = 1'b1;
        end
        for (int i = 0; i < 16; i++) if (mg[i] && ms[i]) n++;
        return n;
    endfunction

    task automatic model_edge(bit rst, bit en, logic [15:0] sw);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i] = 0; m_b[i] = 0; m_c[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
                m_rnd[i] = 0; m_inv[i] = 0; m_s1[i] = '0; m_s2[i] = '0;
            end else begin
                m_inv[i] = 0;
                if (en) begin
                    if (m_st[i] <= 3 && !is_valid(sw)) begin
                        m_inv[i] = 1;
                    end else if (m_st[i] == 0) begin
                        m_s1[i] = sw; m_st[i] = 1;
                    end else if (m_st[i] == 1) begin
                        m_s2[i] = sw; m_st[i] = 2;
                    end else if (m_st[i] == 2 || m_st[i] == 3) begin
                        logic [15:0] tgt = (m_st[i] == 2) ? m_s2[i] : m_s1[i];
                        m_b[i] = count_bulls(sw, tgt);
                        m_c[i] = count_common(sw, tgt) - m_b[i];
                        if (m_b[i] == 4) begin
                            if (m_st[i] == 2) m_p1[i] = (m_p1[i] < m_pmax[i]) ? m_p1[i] + 1 : m_p1[i];
                            else              m_p2[i] = (m_p2[i] < m_pmax[i]) ? m_p2[i] + 1 : m_p2[i];
                            m_st[i] = 7;
                        end else if (m_st[i] == 2) begin
                            m_st[i] = 3;
                        end else begin
                            if (m_rnd[i] < 255) m_rnd[i]++;
                            m_st[i] = (m_maxr[i] != 0 && m_rnd[i] == m_maxr[i]) ? 6 : 2;
                        end
                    end else begin
                        m_st[i] = 0; m_b[i] = 0; m_c[i] = 0; m_rnd[i] = 0;
                        m_s1[i] = '0; m_s2[i] = '0;
                    end
                end
            end
        end
    endtask

    task automatic step(bit rst, bit en, logic [15:0] sw);
        reset = rst; enter = en; SW = sw;
        @(posedge clock);
        model_edge(rst, en, sw);
        #1;
        enter = 1'b0;
    endtask

    task automatic play_j1_win();
        step(0, 1, 16'h1234);
        step(0, 1, 16'h5678);
        step(0, 1, 16'h5678);
        step(0, 1, 16'h0000);
    endtask

    task automatic test_reset();
        step(1, 0, 16'h0000);
        n_tests++; if ({gs0, b0, c0, inv0, rnd0, p1_0, p2_0} !== 34'd0) begin n_fail++; $display("FAIL reset_dut0: got %h exp 0", {gs0, b0, c0, inv0, rnd0, p1_0, p2_0}); end
        n_tests++; if ({gs1, b1, c1, inv1, rnd1, p1_1, p2_1} !== 22'd0) begin n_fail++; $display("FAIL reset_dut1: got %h exp 0", {gs1, b1, c1, inv1, rnd1, p1_1, p2_1}); end
    endtask

    task automatic test_setup();
        step(0, 1, 16'h1234);
        n_tests++; if (gs0 !== 3'b001 || inv0 !== 1'b0) begin n_fail++; $display("FAIL setup_j1: state=%b inv=%b exp 001/0", gs0, inv0); end
        step(0, 1, 16'h5678);
        n_tests++; if (gs0 !== 3'b010 || inv0 !== 1'b0) begin n_fail++; $display("FAIL setup_j2: state=%b inv=%b exp 010/0", gs0, inv0); end
    endtask

    task automatic test_scoring();
        step(0, 1, 16'h5687);
        n_tests++; if ({b0, c0, gs0} !== {3'd2, 3'd2, 3'b011}) begin n_fail++; $display("FAIL score_5687: b=%0d c=%0d st=%b exp 2/2/011", b0, c0, gs0); end
        step(0, 1, 16'h0000);
        n_tests++; if ({inv0, gs0, b0, c0} !== {1'b1, 3'b011, 3'd2, 3'd2}) begin n_fail++; $display("FAIL score_invalid: inv=%b st=%b b=%0d c=%0d exp 1/011/2/2", inv0, gs0, b0, c0); end
        step(0, 0, 16'h0000);
        n_tests++; if (inv0 !== 1'b0) begin n_fail++; $display("FAIL invalid_pulse_width: inv=%b exp 0", inv0); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'($urandom));
            n_tests++; if ({gs0, b0, c0, inv0, rnd0} !== {3'b011, 3'd2, 3'd2, 1'b0, 8'd0}) begin n_fail++; $display("FAIL hold_%0d: st=%b b=%0d c=%0d inv=%b rnd=%0d", i, gs0, b0, c0, inv0, rnd0); end
        end
    endtask

    task automatic test_win();
        step(0, 1, 16'h1234);
        n_tests++; if ({b0, c0, p2_0, p1_0, gs0} !== {3'd4, 3'd0, 8'd1, 8'd0, 3'b111}) begin n_fail++; $display("FAIL win: b=%0d c=%0d p2=%0d p1=%0d st=%b exp 4/0/1/0/111", b0, c0, p2_0, p1_0, gs0); end
        step(0, 1, 16'h12A4);
        n_tests++; if ({gs0, b0, c0, rnd0, p2_0, inv0} !== {3'b000, 3'd0, 3'd0, 8'd0, 8'd1, 1'b0}) begin n_fail++; $display("FAIL restart: st=%b b=%0d c=%0d rnd=%0d p2=%0d inv=%b", gs0, b0, c0, rnd0, p2_0, inv0); end
        n_tests++; if (p2_1 !== 2'd1) begin n_fail++; $display("FAIL win_dut1: p2=%0d exp 1", p2_1); end
    endtask

    task automatic test_reject();
        step(0, 1, 16'h12A4);
        n_tests++; if ({inv0, gs0} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL reject_range: inv=%b st=%b exp 1/000", inv0, gs0); end
        step(0, 1, 16'h1224);
        n_tests++; if ({inv0, gs0} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL reject_dup: inv=%b st=%b exp 1/000", inv0, gs0); end
        step(0, 1, 16'h1234);
        n_tests++; if ({inv0, gs0} !== {1'b0, 3'b001}) begin n_fail++; $display("FAIL accept_after_reject: inv=%b st=%b exp 0/001", inv0, gs0); end
    endtask

    task automatic test_draw();
        step(0, 1, 16'h5678);
        for (int r = 1; r <= 2; r++) begin
            step(0, 1, 16'h0129);
            step(0, 1, 16'h9870);
            n_tests++; if (rnd1 !== 8'(r) || rnd0 !== 8'(r)) begin n_fail++; $display("FAIL draw_round%0d: dut0=%0d dut1=%0d exp %0d", r, rnd0, rnd1, r); end
        end
        n_tests++; if (gs1 !== 3'b110 || p1_1 !== 2'd0 || p2_1 !== 2'd1) begin n_fail++; $display("FAIL draw_state: st=%b p1=%0d p2=%0d exp 110/0/1", gs1, p1_1, p2_1); end
        n_tests++; if (gs0 !== 3'b010) begin n_fail++; $display("FAIL unlimited_rounds: st=%b exp 010", gs0); end
    endtask

    task automatic test_midgame_reset();
        step(1, 0, 16'h0000);
        for (int i = 0; i < 3; i++) play_j1_win();
        n_tests++; if (p1_0 !== 8'd3 || p1_1 !== 2'd3) begin n_fail++; $display("FAIL three_wins: dut0=%0d dut1=%0d exp 3", p1_0, p1_1); end
        step(0, 1, 16'h1234);
        step(0, 1, 16'h5678);
        step(0, 1, 16'h0129);
        n_tests++; if (gs0 !== 3'b011) begin n_fail++; $display("FAIL pre_reset_state: st=%b exp 011", gs0); end
        step(1, 1, 16'h1234);
        n_tests++; if ({gs0, b0, c0, inv0, rnd0, p1_0, p2_0} !== 34'd0) begin n_fail++; $display("FAIL midgame_reset: got %h exp 0", {gs0, b0, c0, inv0, rnd0, p1_0, p2_0}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) play_j1_win();
        n_tests++; if (p1_1 !== 2'd3) begin n_fail++; $display("FAIL saturation: p1=%0d exp 3", p1_1); end
        n_tests++; if (p1_0 !== 8'd4) begin n_fail++; $display("FAIL no_saturation: p1=%0d exp 4", p1_0); end
    endtask

    function automatic logic [15:0] rand_valid();
        logic [15:0] v = '0;
        bit   [9:0]  used = '0;
        for (int i = 0; i < 4; i++) begin
            int d;
            do d = $urandom_range(0, 9); while (used[d]);
            used[d] = 1'b1;
            v[i*4 +: 4] = 4'(d);
        end
        return v;
    endfunction

    task automatic test_random();
        logic [33:0] e0;
        logic [21:0] e1;
        step(1, 0, 16'h0000);
        for (int n = 0; n < 3000; n++) begin
            int          sel = $urandom_range(0, 7);
            logic [15:0] sw;
            if (sel == 0)      sw = (m_st[0] == 2) ? m_s2[0] : m_s1[0];
            else if (sel < 5)  sw = rand_valid();
            else               sw = 16'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), sw);
            e0 = {3'(m_st[0]), 3'(m_b[0]), 3'(m_c[0]), 8'(m_p1[0]), 8'(m_p2[0]), 1'(m_inv[0]), 8'(m_rnd[0])};
            e1 = {3'(m_st[1]), 3'(m_b[1]), 3'(m_c[1]), 2'(m_p1[1]), 2'(m_p2[1]), 1'(m_inv[1]), 8'(m_rnd[1])};
            n_tests++; if ({gs0, b0, c0, p1_0, p2_0, inv0, rnd0} !== e0) begin n_fail++; $display("FAIL random_dut0 @%0d: got %h exp %h", n, {gs0, b0, c0, p1_0, p2_0, inv0, rnd0}, e0); end
            n_tests++; if ({gs1, b1, c1, p1_1, p2_1, inv1, rnd1} !== e1) begin n_fail++; $display("FAIL random_dut1 @%0d: got %h exp %h", n, {gs1, b1, c1, p1_1, p2_1, inv1, rnd1}, e1); end
        end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_scoring();
        test_hold();
        test_win();
        test_reject();
        test_draw();
        test_midgame_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
